// File: rtl/irq_split_pkg.sv
// Shared constants and types for the irq_split interrupt fan-out block.
// Line count and pulse-counter width are fixed here and are not overridable.
package irq_split_pkg;

    localparam int IRQ_LINES = 4;
    localparam int CNT_W     = 8;

    // Registered state of one interrupt line as seen by the top level.
    typedef struct packed {
        logic pending;
        logic pulse;
        logic overflow;
    } line_out_t;

endpackage : irq_split_pkg

// File: rtl/irq_line.sv
// One interrupt line: synchroniser, rising-edge detect, pending/overflow flags
// and a retriggerable pulse counter.
module irq_line
    import irq_split_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 8
) (
    input  logic      aclk,
    input  logic      aresetn,
    input  logic      irq_in,
    input  logic      enable,
    input  logic      ack,
    output line_out_t line_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sync_s;
    logic                   evt;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], irq_in};
        sync_s     = sync_q[SYNC_STAGES-1];
        prev_d     = sync_s;
        evt        = sync_s & ~prev_q & enable;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;

        // A new event beats a same-cycle ack so the fresh interrupt is never lost.
        if (evt) begin
            pending_d = 1'b1;
        end else if (ack) begin
            pending_d = 1'b0;
        end

        if (evt && pending_q && !ack) begin
            overflow_d = 1'b1;
        end else if (ack) begin
            overflow_d = 1'b0;
        end

        if (evt) begin
            cnt_d = CNT_W'(PULSE_LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments, and the async reset
    // clears the synchroniser chain too so no stale level survives reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign line_out.pending  = pending_q;
    assign line_out.pulse    = (cnt_q != '0);
    assign line_out.overflow = overflow_q;

endmodule : irq_line

// File: rtl/irq_split.sv
// Fans a packed 4-bit level interrupt vector out into four independent
// latched/pulsed interrupt lines for the DMA, switch and timer consumers.
module irq_split
    import irq_split_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [IRQ_LINES-1:0] concated,
    input  logic [IRQ_LINES-1:0] enable,
    input  logic [IRQ_LINES-1:0] ack,
    (* X_INTERFACE_PARAMETER = "SENSITIVITY LEVEL_HIGH" *)
    output logic                 irq0,
    (* X_INTERFACE_PARAMETER = "SENSITIVITY LEVEL_HIGH" *)
    output logic                 irq1,
    (* X_INTERFACE_PARAMETER = "SENSITIVITY LEVEL_HIGH" *)
    output logic                 irq2,
    (* X_INTERFACE_PARAMETER = "SENSITIVITY LEVEL_HIGH" *)
    output logic                 irq3,
    (* X_INTERFACE_PARAMETER = "SENSITIVITY EDGE_RISING" *)
    output logic [IRQ_LINES-1:0] irq_pulse,
    output logic [IRQ_LINES-1:0] overflow
);

    line_out_t line_out [IRQ_LINES];

    for (genvar i = 0; i < IRQ_LINES; i++) begin : g_line
        irq_line #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN)
        ) u_line (
            .aclk     (aclk),
            .aresetn  (aresetn),
            .irq_in   (concated[i]),
            .enable   (enable[i]),
            .ack      (ack[i]),
            .line_out (line_out[i])
        );
    end

    always_comb begin
        irq_pulse = '0;
        overflow  = '0;
        for (int i = 0; i < IRQ_LINES; i++) begin
            irq_pulse[i] = line_out[i].pulse;
            overflow[i]  = line_out[i].overflow;
        end
    end

    assign irq0 = line_out[0].pending;
    assign irq1 = line_out[1].pending;
    assign irq2 = line_out[2].pending;
    assign irq3 = line_out[3].pending;

endmodule : irq_split
